// File: rtl/sram_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_pkg
// Brief    : Shared types, encodings and the arbitration helper for sram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WAIT   = 2'b10,
      ST_RESP   = 2'b11
   } state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

   localparam int c_wait_min = 1;
   localparam int c_wait_max = 15;
   localparam int c_cnt_w    = 4;

   // On a tie the side that did not win last time is served, so neither starves.
   function automatic grant_t pick_winner(input logic i_cand, input logic d_cand,
                                          input grant_t last);
      if (i_cand && d_cand)
         return (last == GRANT_I) ? GRANT_D : GRANT_I;
      else if (d_cand)
         return GRANT_D;
      else
         return GRANT_I;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_if
// Brief    : Requester and SRAM bus bundle around the shared-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if;
   logic        flush;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_valid;
   logic        d_req;
   logic [3:0]  d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        stallreq_mem;
   logic        sram_ce;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   modport slave (
      input  flush, i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
      output i_rdata, i_valid, d_rdata, d_valid, stallreq_mem,
             sram_ce, sram_we, sram_addr, sram_wdata
   );

   modport master (
      output flush, i_req, i_addr, d_req, d_we, d_addr, d_wdata, sram_rdata,
      input  i_rdata, i_valid, d_rdata, d_valid, stallreq_mem,
             sram_ce, sram_we, sram_addr, sram_wdata
   );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Shares one single-port synchronous SRAM between fetch and data sides.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  wire           cpu_clk_50M,
   input  wire           cpu_rst,
   sram_arbiter_if.slave bus
);

   generate
      if (WAIT_CYCLES < c_wait_min || WAIT_CYCLES > c_wait_max) begin : g_wait_range_err
         $error("sram_arbiter: WAIT_CYCLES must lie in 1..15");
      end
   endgenerate

   localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES);

   state_t               r_state;
   grant_t               r_grant;
   grant_t               r_last_grant;
   logic [31:2]          r_addr;
   logic [3:0]           r_we;
   logic [31:0]          r_wdata;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [31:0]          r_i_rdata;
   logic [31:0]          r_d_rdata;
   logic                 r_i_flushed;

   state_t               w_state_nxt;
   grant_t               w_grant_nxt;
   logic                 w_i_cand;
   logic                 w_grant_take;
   logic                 w_capture;
   logic                 w_sram_ce;
   logic                 w_i_valid;
   logic                 w_d_valid;

   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_i_cand     = bus.i_req & ~bus.flush;
      w_grant_take = 1'b0;
      w_capture    = 1'b0;
      w_sram_ce    = 1'b0;
      w_i_valid    = 1'b0;
      w_d_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_i_cand || bus.d_req) begin
               w_grant_take = 1'b1;
               w_grant_nxt  = pick_winner(w_i_cand, bus.d_req, r_last_grant);
               w_state_nxt  = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_sram_ce   = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (r_cnt == c_cnt_w'(1)) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_i_valid   = (r_grant == GRANT_I) & ~r_i_flushed & ~bus.flush;
            w_d_valid   = (r_grant == GRANT_D);
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
      if (cpu_rst) begin
         r_grant      <= GRANT_I;
         r_last_grant <= GRANT_I;
         r_addr       <= '0;
         r_we         <= '0;
         r_wdata      <= '0;
         r_cnt        <= '0;
         r_i_rdata    <= '0;
         r_d_rdata    <= '0;
         r_i_flushed  <= 1'b0;
      end else begin
         if (w_grant_take) begin
            r_grant     <= w_grant_nxt;
            r_i_flushed <= 1'b0;
            if (w_grant_nxt == GRANT_D) begin
               r_addr  <= bus.d_addr[31:2];
               r_we    <= bus.d_we;
               r_wdata <= bus.d_wdata;
            end else begin
               r_addr  <= bus.i_addr[31:2];
               r_we    <= '0;
            end
         end

         if (r_state == ST_ACCESS)
            r_cnt <= c_wait_load;
         else if (r_state == ST_WAIT)
            r_cnt <= r_cnt - c_cnt_w'(1);

         // A flushed fetch still runs on the SRAM; only its completion is hidden.
         if ((r_state == ST_ACCESS || r_state == ST_WAIT) &&
             r_grant == GRANT_I && bus.flush)
            r_i_flushed <= 1'b1;

         if (w_capture) begin
            if (r_grant == GRANT_D)
               r_d_rdata <= bus.sram_rdata;
            else
               r_i_rdata <= bus.sram_rdata;
         end

         if (r_state == ST_RESP)
            r_last_grant <= r_grant;
      end
   end

   assign bus.sram_ce      = w_sram_ce;
   assign bus.sram_we      = (w_sram_ce && r_grant == GRANT_D) ? r_we : 4'b0000;
   assign bus.sram_addr    = {r_addr, 2'b00};
   assign bus.sram_wdata   = r_wdata;
   assign bus.i_rdata      = r_i_rdata;
   assign bus.d_rdata      = r_d_rdata;
   assign bus.i_valid      = w_i_valid;
   assign bus.d_valid      = w_d_valid;
   assign bus.stallreq_mem = (bus.i_req & ~w_i_valid & ~bus.flush) |
                             (bus.d_req & ~w_d_valid);

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Brief    : Scoreboard bench for sram_arbiter at WAIT_CYCLES of 1, 3 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

   typedef struct {
      bit          is_d;
      bit          chk;
      logic [31:0] data;
      int          cyc;
   } resp_t;

   logic clk;
   logic rst_a, rst_b, rst_c;
   int   cyc;
   int   checks;
   int   errors;

   resp_t q_a[$];
   resp_t q_b[$];
   resp_t q_c[$];
   resp_t e_a, e_b, e_c;

   sram_arbiter_if a_bus ();
   sram_arbiter_if b_bus ();
   sram_arbiter_if c_bus ();

   sram_arbiter #(.WAIT_CYCLES(1)) u_dut_a (.cpu_clk_50M(clk), .cpu_rst(rst_a), .bus(a_bus));
   sram_arbiter #(.WAIT_CYCLES(3)) u_dut_b (.cpu_clk_50M(clk), .cpu_rst(rst_b), .bus(b_bus));
   sram_arbiter #(.WAIT_CYCLES(4)) u_dut_c (.cpu_clk_50M(clk), .cpu_rst(rst_c), .bus(c_bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_init(input int idx);
      case (idx)
         'h40:    return 32'h2402_0005;
         'h80:    return 32'hDEAD_BEEF;
         'hC0:    return 32'h1122_3344;
         default: return 32'h5A5A_0000 | 32'(idx);
      endcase
   endfunction

   // Instance A sees a real word memory; B and C see data that changes every cycle.
   logic [31:0] mem_a [0:255];
   always @(posedge clk) begin
      if (rst_a) begin
         for (int k = 0; k < 256; k++) mem_a[k] <= mem_init(k);
      end else if (a_bus.sram_ce) begin
         for (int b = 0; b < 4; b++)
            if (a_bus.sram_we[b])
               mem_a[a_bus.sram_addr[9:2]][8*b +: 8] <= a_bus.sram_wdata[8*b +: 8];
         a_bus.sram_rdata <= mem_a[a_bus.sram_addr[9:2]];
      end
   end
   assign b_bus.sram_rdata = 32'hB000_0000 | 32'(cyc);
   assign c_bus.sram_rdata = 32'hC000_0000 | 32'(cyc);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic score(input string nm, input resp_t e, input logic is_d,
                        input logic [31:0] ir, input logic [31:0] dr, input int now);
      check({nm, "_side"}, 32'(is_d), 32'(e.is_d));
      check({nm, "_cycle"}, now, e.cyc);
      if (e.chk) check({nm, "_data"}, is_d ? dr : ir, e.data);
   endtask

   always @(negedge clk) begin
      if (a_bus.i_valid || a_bus.d_valid) begin
         if (q_a.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
         else begin
            e_a = q_a.pop_front();
            score("a_resp", e_a, a_bus.d_valid, a_bus.i_rdata, a_bus.d_rdata, cyc);
         end
      end
      if (b_bus.i_valid || b_bus.d_valid) begin
         if (q_b.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
         else begin
            e_b = q_b.pop_front();
            score("b_resp", e_b, b_bus.d_valid, b_bus.i_rdata, b_bus.d_rdata, cyc);
         end
      end
      if (c_bus.i_valid || c_bus.d_valid) begin
         if (q_c.size() == 0) check("c_unexpected_valid", 32'd1, 32'd0);
         else begin
            e_c = q_c.pop_front();
            score("c_resp", e_c, c_bus.d_valid, c_bus.i_rdata, c_bus.d_rdata, cyc);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic a_d_access(input logic [31:0] addr, input logic [3:0] we,
                             input logic [31:0] wd, input logic [31:0] exp, input bit chk);
      int t0;
      a_bus.d_req   = 1'b1;
      a_bus.d_addr  = addr;
      a_bus.d_we    = we;
      a_bus.d_wdata = wd;
      t0 = cyc;
      q_a.push_back('{1'b1, chk, exp, t0 + 3});
      sample();
      check("d_stall_c0", a_bus.stallreq_mem, 1);
      next_cycle();
      sample();
      check("d_ce_c1", a_bus.sram_ce, 1);
      check("d_addr_c1", a_bus.sram_addr, {addr[31:2], 2'b00});
      check("d_we_c1", a_bus.sram_we, we);
      if (we != 4'b0000) check("d_wdata_c1", a_bus.sram_wdata, wd);
      next_cycle();
      sample();
      check("d_we_c2", a_bus.sram_we, 0);
      next_cycle();
      next_cycle();
      a_bus.d_req = 1'b0;
   endtask

   task automatic a_tie(input bit d_first);
      int t0;
      a_bus.i_req  = 1'b1;
      a_bus.i_addr = 32'h0000_0100;
      a_bus.d_req  = 1'b1;
      a_bus.d_addr = 32'h0000_0200;
      a_bus.d_we   = 4'b0000;
      t0 = cyc;
      if (d_first) begin
         q_a.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, t0 + 3});
         q_a.push_back('{1'b0, 1'b1, 32'h2402_0005, t0 + 7});
      end else begin
         q_a.push_back('{1'b0, 1'b1, 32'h2402_0005, t0 + 3});
         q_a.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, t0 + 7});
      end
      sample();
      check("tie_stall_c0", a_bus.stallreq_mem, 1);
      next_cycle();
      sample();
      check("tie_first_addr", a_bus.sram_addr, d_first ? 32'h200 : 32'h100);
      next_cycle();
      next_cycle();
      next_cycle();
      if (d_first) a_bus.d_req = 1'b0;
      else         a_bus.i_req = 1'b0;
      next_cycle();
      sample();
      check("tie_second_ce", a_bus.sram_ce, 1);
      check("tie_second_addr", a_bus.sram_addr, d_first ? 32'h100 : 32'h200);
      next_cycle();
      next_cycle();
      next_cycle();
      a_bus.i_req = 1'b0;
      a_bus.d_req = 1'b0;
   endtask

   task automatic clear_inputs(output logic fl, output logic ir, output logic [31:0] ia,
                               output logic dr, output logic [3:0] dw,
                               output logic [31:0] da, output logic [31:0] dd);
      fl = 1'b0; ir = 1'b0; ia = '0; dr = 1'b0; dw = '0; da = '0; dd = '0;
   endtask

   initial begin
      int t0;
      checks = 0;
      errors = 0;
      clear_inputs(a_bus.flush, a_bus.i_req, a_bus.i_addr, a_bus.d_req, a_bus.d_we,
                   a_bus.d_addr, a_bus.d_wdata);
      clear_inputs(b_bus.flush, b_bus.i_req, b_bus.i_addr, b_bus.d_req, b_bus.d_we,
                   b_bus.d_addr, b_bus.d_wdata);
      clear_inputs(c_bus.flush, c_bus.i_req, c_bus.i_addr, c_bus.d_req, c_bus.d_we,
                   c_bus.d_addr, c_bus.d_wdata);
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      next_cycle();
      next_cycle();
      sample();
      check("rst_i_valid", a_bus.i_valid, 0);
      check("rst_d_valid", a_bus.d_valid, 0);
      check("rst_i_rdata", a_bus.i_rdata, 0);
      check("rst_d_rdata", a_bus.d_rdata, 0);
      check("rst_ce_we", {a_bus.sram_ce, a_bus.sram_we}, 0);
      check("rst_addr", a_bus.sram_addr, 0);
      check("rst_wdata", a_bus.sram_wdata, 0);
      check("rst_stall", a_bus.stallreq_mem, 0);
      next_cycle();
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      next_cycle();

      // Single fetch from an unaligned address.
      a_bus.i_req  = 1'b1;
      a_bus.i_addr = 32'h0000_0103;
      t0 = cyc;
      q_a.push_back('{1'b0, 1'b1, 32'h2402_0005, t0 + 3});
      sample();
      check("i_stall_c0", a_bus.stallreq_mem, 1);
      check("i_ce_c0", a_bus.sram_ce, 0);
      next_cycle();
      sample();
      check("i_ce_c1", a_bus.sram_ce, 1);
      check("i_addr_c1", a_bus.sram_addr, 32'h100);
      check("i_we_c1", a_bus.sram_we, 0);
      check("i_stall_c1", a_bus.stallreq_mem, 1);
      next_cycle();
      sample();
      check("i_ce_c2", a_bus.sram_ce, 0);
      check("i_stall_c2", a_bus.stallreq_mem, 1);
      next_cycle();
      sample();
      check("i_stall_c3", a_bus.stallreq_mem, 0);
      next_cycle();
      a_bus.i_req = 1'b0;

      a_tie(1'b1);

      a_d_access(32'h0000_0300, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
      a_d_access(32'h0000_0300, 4'b0000, 32'h0, 32'h1122_AB44, 1'b1);

      // Last grant was D, so this tie must go to I first.
      a_tie(1'b0);

      // Fetch aborted by reset during WAIT; afterwards a tie goes to D.
      a_bus.i_req  = 1'b1;
      a_bus.i_addr = 32'h0000_0100;
      next_cycle();
      next_cycle();
      a_bus.i_req = 1'b0;
      rst_a = 1'b1;
      #1;
      check("mid_rst_i_rdata", a_bus.i_rdata, 0);
      check("mid_rst_d_rdata", a_bus.d_rdata, 0);
      check("mid_rst_addr", a_bus.sram_addr, 0);
      check("mid_rst_wdata", a_bus.sram_wdata, 0);
      check("mid_rst_ce_we", {a_bus.sram_ce, a_bus.sram_we}, 0);
      check("mid_rst_valid", {a_bus.i_valid, a_bus.d_valid}, 0);
      next_cycle();
      next_cycle();
      rst_a = 1'b0;
      next_cycle();
      a_tie(1'b1);

      // WAIT_CYCLES=3: flush in WAIT hides the fetch; a D request placed in RESP is served from cycle 6.
      b_bus.i_req  = 1'b1;
      b_bus.i_addr = 32'h0000_0100;
      t0 = cyc;
      next_cycle();
      sample();
      check("fl_ce_c1", b_bus.sram_ce, 1);
      next_cycle();
      next_cycle();
      b_bus.flush = 1'b1;
      sample();
      check("fl_stall_c3", b_bus.stallreq_mem, 0);
      next_cycle();
      b_bus.flush = 1'b0;
      b_bus.i_req = 1'b0;
      next_cycle();
      b_bus.d_req  = 1'b1;
      b_bus.d_addr = 32'h0000_0040;
      b_bus.d_we   = 4'b0000;
      q_b.push_back('{1'b1, 1'b1, 32'hB000_0000 | 32'(t0 + 10), t0 + 11});
      sample();
      check("fl_stall_c5", b_bus.stallreq_mem, 1);
      next_cycle();
      next_cycle();
      sample();
      check("fl_ce_c7", b_bus.sram_ce, 1);
      check("fl_addr_c7", b_bus.sram_addr, 32'h40);
      repeat (5) next_cycle();
      b_bus.d_req = 1'b0;

      // WAIT_CYCLES=4: capture point checked against per-cycle changing data.
      c_bus.i_req  = 1'b1;
      c_bus.i_addr = 32'h0000_0080;
      t0 = cyc;
      q_c.push_back('{1'b0, 1'b1, 32'hC000_0000 | 32'(t0 + 5), t0 + 6});
      next_cycle();
      sample();
      check("sw_ce_c1", c_bus.sram_ce, 1);
      next_cycle();
      sample();
      check("sw_ce_c2", c_bus.sram_ce, 0);
      repeat (5) next_cycle();
      c_bus.i_req  = 1'b0;
      c_bus.d_req  = 1'b1;
      c_bus.d_addr = 32'h0000_0044;
      c_bus.d_we   = 4'b0000;
      q_c.push_back('{1'b1, 1'b1, 32'hC000_0000 | 32'(t0 + 12), t0 + 13});
      repeat (7) next_cycle();
      c_bus.d_req = 1'b0;

      repeat (4) next_cycle();
      check("a_pending", q_a.size(), 0);
      check("b_pending", q_b.size(), 0);
      check("c_pending", q_c.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Shares a single-port synchronous SRAM between the instruction-fetch side (`if_stage`) and the data side (`mem_stage`) of the MiniMIPS32 core on the single-memory SoC variant. It arbitrates requests, sequences each access through a small state machine with a parameterised read latency, and returns registered read data with a one-cycle valid pulse. While any request is unserved it raises a stall request toward `scu`. Flushes from `cp0_reg` discard in-flight instruction results.

## Interface
- `WAIT_CYCLES`, default 1: SRAM cycles from the `sram_ce` cycle to the edge where `sram_rdata` is sampled. Legal range is 1–15.
- `cpu_clk_50M`  in  1  single clock, rising edge.
- `cpu_rst`  in  1  reset. Asynchronous and active-high.
- `flush`  in  1  exception flush from `cp0_reg`.
- `i_req`  in  1  instruction read request.
- `i_addr`  in  32  byte address.
- `i_rdata`  out  32  instruction word.
- `i_valid`  out  1  one-cycle completion pulse.
- `d_req`  in  1  data request.
- `d_we`  in  4  byte write enables; 0 means read.
- `d_addr`  in  32  data address.
- `d_wdata`  in  32  data to write.
- `d_rdata`  out  32  data read.
- `d_valid`  out  1  one-cycle completion pulse.
- `stallreq_mem`  out  1  stall request to `scu`.
- `sram_ce`  out  1  SRAM chip enable.
- `sram_we`  out  4  SRAM byte write enables.
- `sram_addr`  out  32  SRAM address; bits [1:0] are forced to 0.
- `sram_wdata`  out  32  SRAM write data.
- `sram_rdata`  in  32  SRAM read data.

## Operation
- **Requester rule.** A requester holds `req`, address, `we` and `wdata` stable until its `valid` pulse. If a requester drops `req` early, the access still completes and its `valid` pulse is still issued.
- **States.** IDLE, ACCESS, WAIT, RESP. Encoded 2'b00, 01, 10, 11.
- **IDLE.** Selects a winner from `d_req` and `i_req & ~flush`.
  - Only one request pending: that requester wins.
  - Both pending: the requester not named by `last_grant` wins.
  - On a grant, latch `grant`, address, `we` and `wdata`; go to ACCESS.
- **ACCESS.** Exactly one cycle.
  - `sram_ce`=1; `sram_addr`, `sram_we` and `sram_wdata` are driven from the latches.
  - `sram_we` = latched `d_we` for a D grant, 0 for an I grant.
  - Load counter with `WAIT_CYCLES`; go to WAIT.
- **WAIT.** Decrement the counter each cycle.
  - When the counter reaches 1, capture `sram_rdata` into the grant's rdata register at that edge.
  - Go to RESP.
- **RESP.** One cycle.
  - Pulse the grant's `valid`, except when suppressed by a flush (below).
  - Update `last_grant` := `grant`; go to IDLE.
- **Writes.** Follow the same sequence. `d_rdata` is still captured and is don't-care.
- **Flush.** When `flush`=1 during ACCESS, WAIT or RESP of an I grant, the SRAM access completes but `i_valid` is suppressed.
  - A D access is never cancelled, because the store has already been issued.
- **Stall.** `stallreq_mem` = (`i_req & ~i_valid & ~flush`) | (`d_req & ~d_valid`). This is combinational.
- **Idle outputs.** `sram_ce`=0, `sram_we`=0, and `sram_addr`/`sram_wdata` hold their last values.

## Timing
- **Reset values.** All outputs 0. State IDLE, counter 0, latches 0, `last_grant`=I, so the first tie is granted to D.
- **Latency.** With the request seen in IDLE at cycle t:
  - `sram_ce` is high in t+1.
  - Data is sampled at the end of cycle t+1+`WAIT_CYCLES`.
  - `valid` is high in t+2+`WAIT_CYCLES`; rdata is stable from that cycle until the next capture.
  - For `WAIT_CYCLES`=1, `valid` arrives 3 cycles after the request cycle.
- **Throughput.** The earliest next grant is in the IDLE cycle following RESP. The access period is therefore `WAIT_CYCLES`+3 cycles.
- **Simultaneous requests.** They alternate strictly under the `last_grant` rule, so neither side can starve.
- **Reset mid-access.** Asynchronously returns to IDLE with reset values. No `valid` pulse is issued. A write that was already issued in ACCESS may have taken effect.
- **Request arriving in RESP.** It is not seen until IDLE.

## Structure
- State encodings and the `GRANT_I`/`GRANT_D` constants go in `defines.v`, next to the existing `STALL_BUS` definitions.
- `WAIT_CYCLES` bounds are checked with an elaboration-time guard.
- Single module with no sub-modules. The counter is 4 bits.

## Test plan
- **Single I read.** `WAIT_CYCLES`=1; SRAM word at 0x0000_0100 = 0x2402_0005; `i_req` with `i_addr`=0x103 at cycle 0 → `sram_ce` high at cycle 1 with `sram_addr`=0x100; `i_valid` high at cycle 3 with `i_rdata`=0x2402_0005; `stallreq_mem` high during cycles 0–2.
- **Tie and alternation.** `i_req` and `d_req` both asserted at cycle 0 (read from 0x200) → D is granted first, `d_valid` at cycle 3; I granted at cycle 4, `i_valid` at cycle 7.
- **Byte write then readback.** D write with `d_we`=4'b0010, `d_wdata`=0x0000_AB00 to 0x300 (initially 0x1122_3344) → `sram_we`=0010 for one cycle; a subsequent D read of 0x300 returns 0x1122_AB44.
- **Flush during I access.** `flush` pulsed during WAIT of an I read with `WAIT_CYCLES`=3 → no `i_valid` pulse; the state machine returns to IDLE at the normal time (cycle 6).
- **Reset mid-access.** `cpu_rst` asserted during WAIT → all outputs 0 in the same cycle, no `valid` pulse; after release, a tied request goes to D.
- **Latency parameter sweep.** `WAIT_CYCLES`=4 → `valid` at cycle 6 and rdata is sampled exactly at the end of cycle 5; checked with an SRAM model that changes data every cycle.
